// File: rtl/i2c_pkg.sv
// Shared types for the I2C write initiator: FSM states, quarter encoding, byte width,
// and the per-quarter SCL/SDA pull-down table.
package i2c_pkg;

    localparam int   BYTE_W     = 8;
    localparam logic I2C_WR_BIT = 1'b0;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ACK1, REG, ACK2, DATA, ACK3, STOP
    } state_t;

    typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quarter_t;

    // Returns {scl_oe, sda_oe} for a state/quarter; b is the bit being shifted out.
    function automatic logic [1:0] line_drive(state_t st, quarter_t q, logic b);
        logic low_half;
        low_half = (q == Q0) || (q == Q1);
        case (st)
            START:            line_drive = {1'b0, !low_half};
            ADDR, REG, DATA:  line_drive = {low_half, !b};
            ACK1, ACK2, ACK3: line_drive = {low_half, 1'b0};
            STOP:             line_drive = {low_half, q != Q3};
            default:          line_drive = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/i2c_master_wr_if.sv
// Request/status handshake plus open-drain pad signals of the I2C write initiator.
// master = initiator side, slave = requester and pad/bus side.
interface i2c_master_wr_if;
    import i2c_pkg::*;

    logic       start;
    logic [6:0] dev_addr;
    byte_t      reg_addr;
    byte_t      wr_data;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       scl_i;
    logic       scl_oe;
    logic       sda_i;
    logic       sda_oe;

    modport master (
        input  start, dev_addr, reg_addr, wr_data, scl_i, sda_i,
        output busy, done, ack_err, scl_oe, sda_oe
    );

    modport slave (
        output start, dev_addr, reg_addr, wr_data, scl_i, sda_i,
        input  busy, done, ack_err, scl_oe, sda_oe
    );

endinterface

// File: rtl/i2c_quarter_tick.sv
// SCL quarter-period divider: qtick on the last cycle of each quarter, qfirst on its first.
// I2C_MASTER_STRETCH_EN: divider holds in Q2/Q3 while scl_in is low (slave stretching).
module i2c_quarter_tick
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     run,
`ifdef I2C_MASTER_STRETCH_EN
    input  logic     scl_in,
`endif
    output logic     qtick,
    output logic     qfirst,
    output quarter_t quarter
);
    localparam int            DW   = $clog2(CLK_DIV);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] cnt;
    logic          hold;
    logic          adv;

`ifdef I2C_MASTER_STRETCH_EN
    assign hold = (quarter == Q2 || quarter == Q3) && !scl_in;
`else
    assign hold = 1'b0;
`endif

    assign adv    = run && !hold;
    assign qtick  = adv && (cnt == LAST);
    assign qfirst = adv && (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            quarter <= Q0;
        end else if (!run) begin
            cnt     <= '0;
            quarter <= Q0;
        end else if (adv) begin
            if (cnt == LAST) begin
                cnt     <= '0;
                quarter <= quarter_t'(quarter + 2'd1);
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_master_wr.sv
// I2C write initiator: START, {dev_addr,W}, reg_addr, wr_data, STOP with ACK checks; 116*CLK_DIV cycles.
// start is ignored while busy; optional clock stretching via I2C_MASTER_STRETCH_EN.
module i2c_master_wr
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input logic            clk,
    input logic            rst,
    i2c_master_wr_if.master bus
);
    state_t     state;
    quarter_t   quarter;
    logic       qtick;
    logic       qfirst;
    byte_t      sr;
    byte_t      reg_q;
    byte_t      dat_q;
    logic [2:0] bitcnt;
    logic       ack_smp;
    logic       busy_q;
    logic       done_q;
    logic       ack_err_q;
    logic       scl_oe_q;
    logic       sda_oe_q;

    i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .run     (state != IDLE),
`ifdef I2C_MASTER_STRETCH_EN
        .scl_in  (bus.scl_i),
`endif
        .qtick   (qtick),
        .qfirst  (qfirst),
        .quarter (quarter)
    );

    // Line drivers are registered one step ahead: each qtick loads the drive for the next quarter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= '0;
            reg_q     <= '0;
            dat_q     <= '0;
            bitcnt    <= '0;
            ack_smp   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            scl_oe_q  <= 1'b0;
            sda_oe_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (qfirst && quarter == Q3)
                ack_smp <= bus.sda_i;

            if (state == IDLE) begin
                if (bus.start) begin
                    state                <= START;
                    busy_q               <= 1'b1;
                    ack_err_q            <= 1'b0;
                    sr                   <= {bus.dev_addr, I2C_WR_BIT};
                    reg_q                <= bus.reg_addr;
                    dat_q                <= bus.wr_data;
                    bitcnt               <= 3'd7;
                    {scl_oe_q, sda_oe_q} <= line_drive(START, Q0, 1'b1);
                end
            end else if (qtick) begin
                if (quarter != Q3) begin
                    {scl_oe_q, sda_oe_q} <= line_drive(state, quarter_t'(quarter + 2'd1), sr[7]);
                end else begin
                    case (state)
                        START: begin
                            state                <= ADDR;
                            {scl_oe_q, sda_oe_q} <= line_drive(ADDR, Q0, sr[7]);
                        end
                        ADDR, REG, DATA: begin
                            if (bitcnt != 3'd0) begin
                                sr                   <= {sr[6:0], 1'b0};
                                bitcnt               <= bitcnt - 3'd1;
                                {scl_oe_q, sda_oe_q} <= line_drive(state, Q0, sr[6]);
                            end else begin
                                state <= (state == ADDR) ? ACK1 : (state == REG) ? ACK2 : ACK3;
                                {scl_oe_q, sda_oe_q} <= line_drive(ACK1, Q0, 1'b0);
                            end
                        end
                        ACK1, ACK2: begin
                            if (ack_smp) begin
                                ack_err_q            <= 1'b1;
                                state                <= STOP;
                                {scl_oe_q, sda_oe_q} <= line_drive(STOP, Q0, 1'b0);
                            end else if (state == ACK1) begin
                                state                <= REG;
                                sr                   <= reg_q;
                                bitcnt               <= 3'd7;
                                {scl_oe_q, sda_oe_q} <= line_drive(REG, Q0, reg_q[7]);
                            end else begin
                                state                <= DATA;
                                sr                   <= dat_q;
                                bitcnt               <= 3'd7;
                                {scl_oe_q, sda_oe_q} <= line_drive(DATA, Q0, dat_q[7]);
                            end
                        end
                        ACK3: begin
                            if (ack_smp)
                                ack_err_q <= 1'b1;
                            state                <= STOP;
                            {scl_oe_q, sda_oe_q} <= line_drive(STOP, Q0, 1'b0);
                        end
                        STOP: begin
                            state                <= IDLE;
                            busy_q               <= 1'b0;
                            done_q               <= 1'b1;
                            {scl_oe_q, sda_oe_q} <= 2'b00;
                        end
                        default: begin
                            state                <= IDLE;
                            busy_q               <= 1'b0;
                            {scl_oe_q, sda_oe_q} <= 2'b00;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.ack_err = ack_err_q;
    assign bus.scl_oe  = scl_oe_q;
    assign bus.sda_oe  = sda_oe_q;

endmodule

// File: tb/tb_i2c_master_wr.sv
// Bench for i2c_master_wr: open-drain bus with a behavioural I2C slave, table-driven transactions
// and directed sequences for held start, mid-transaction reset and (I2C_MASTER_STRETCH_EN) stretching.
module tb_i2c_master_wr;
    import i2c_pkg::*;

    localparam int CLK_DIV = 4;
    localparam int BUDGET  = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_master_wr_if bus();
    i2c_master_wr #(.CLK_DIV(CLK_DIV)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic slv_scl_low = 1'b0;
    logic slv_sda_low = 1'b0;
    logic scl_w, sda_w;
    assign scl_w     = ~(bus.scl_oe | slv_scl_low);
    assign sda_w     = ~(bus.sda_oe | slv_sda_low);
    assign bus.scl_i = scl_w;
    assign bus.sda_i = sda_w;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural slave: decodes START/STOP, collects bytes, ACKs per ack_en bit.
    int         bitn = 0;
    int         byte_idx = 0;
    int         stops = 0;
    logic [2:0] ack_en = 3'b111;
    byte_t      shreg = '0;
    byte_t      rx[$];
    logic       scl_p = 1'b1;
    logic       sda_p = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            bitn        = 0;
            slv_sda_low = 1'b0;
        end else if (scl_p && scl_w && sda_p && !sda_w) begin
            bitn     = 0;
            byte_idx = 0;
        end else if (scl_p && scl_w && !sda_p && sda_w) begin
            stops++;
        end else if (!scl_p && scl_w) begin
            if (bitn < 8) shreg = {shreg[6:0], sda_w};
            bitn++;
            if (bitn == 8) rx.push_back(shreg);
        end else if (scl_p && !scl_w) begin
            if (bitn == 8) begin
                slv_sda_low = (byte_idx < 3) ? ack_en[byte_idx] : 1'b0;
            end else if (bitn == 9) begin
                slv_sda_low = 1'b0;
                bitn        = 0;
                byte_idx++;
            end
        end
        scl_p = scl_w;
        sda_p = sda_w;
    end

    typedef struct {
        logic [6:0] dev;
        byte_t      rg;
        byte_t      dat;
        logic [2:0] ack;
        int         cyc;
        logic       err;
        int         nbytes;
        byte_t      b0;
        byte_t      b1;
        byte_t      b2;
    } vec_t;

    vec_t vecs[6];

    task automatic launch(input vec_t v);
        ack_en = v.ack;
        rx.delete();
        @(negedge clk);
        bus.dev_addr = v.dev;
        bus.reg_addr = v.rg;
        bus.wr_data  = v.dat;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic run_txn(input vec_t v, input int st_at, input int st_len);
        int n;
        int stops0;
        stops0 = stops;
        launch(v);
        chk("busy_after_accept", bus.busy, 1);
        chk("ack_err_cleared", bus.ack_err, 0);
        n = 0;
        while (!bus.done && n < BUDGET) begin
            @(posedge clk);
            #1;
            n++;
            if (st_len > 0 && n == st_at) slv_scl_low = 1'b1;
            if (st_len > 0 && n == st_at + st_len + 1) slv_scl_low = 1'b0;
        end
        chk("done_cycle", n, v.cyc + st_len);
        chk("ack_err_at_done", bus.ack_err, v.err);
        chk("busy_low_at_done", bus.busy, 0);
        @(posedge clk);
        #1;
        chk("done_one_cycle", bus.done, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("ack_err_held", bus.ack_err, v.err);
        chk("lines_released", {bus.scl_oe, bus.sda_oe}, 0);
        chk("stop_seen", stops - stops0, 1);
        chk("nbytes", rx.size(), v.nbytes);
        if (rx.size() > 0) chk("byte0", rx[0], v.b0);
        if (rx.size() > 1) chk("byte1", rx[1], v.b1);
        if (rx.size() > 2) chk("byte2", rx[2], v.b2);
    endtask

    initial begin
        int n;
        logic done_seen;

        bus.start    = 1'b0;
        bus.dev_addr = '0;
        bus.reg_addr = '0;
        bus.wr_data  = '0;

        // dev, reg, data, ack mask (bit0 = byte 1), done cycle, ack_err, bytes seen, expected bytes
        vecs[0] = '{7'h50, 8'hA5, 8'h3C, 3'b111, 464, 1'b0, 3, 8'hA0, 8'hA5, 8'h3C};
        vecs[1] = '{7'h50, 8'hA5, 8'h3C, 3'b000, 176, 1'b1, 1, 8'hA0, 8'h00, 8'h00};
        vecs[2] = '{7'h50, 8'hA5, 8'h3C, 3'b011, 464, 1'b1, 3, 8'hA0, 8'hA5, 8'h3C};
        vecs[3] = '{7'h7F, 8'h00, 8'hFF, 3'b111, 464, 1'b0, 3, 8'hFE, 8'h00, 8'hFF};
        vecs[4] = '{7'h01, 8'h80, 8'h5A, 3'b001, 320, 1'b1, 2, 8'h02, 8'h80, 8'h00};
        vecs[5] = '{7'h2A, 8'hC3, 8'h81, 3'b111, 464, 1'b0, 3, 8'h54, 8'hC3, 8'h81};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_ack_err", bus.ack_err, 0);
        chk("rst_lines", {bus.scl_oe, bus.sda_oe}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", bus.busy, 0);
        chk("idle_lines", {scl_w, sda_w}, 2'b11);

        for (int i = 0; i < 6; i++)
            run_txn(vecs[i], 0, 0);

        // start held high: one transaction, the next accepted the cycle after done
        ack_en = 3'b111;
        rx.delete();
        @(negedge clk);
        bus.dev_addr = vecs[0].dev;
        bus.reg_addr = vecs[0].rg;
        bus.wr_data  = vecs[0].dat;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        while (!bus.done && n < BUDGET) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("held_first_done", n, 464);
        chk("held_busy_at_done", bus.busy, 0);
        @(posedge clk);
        #1;
        chk("held_second_accept", bus.busy, 1);
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < BUDGET) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("held_second_done", n, 464);
        repeat (20) @(posedge clk);
        #1;
        chk("held_no_third", bus.busy, 0);
        chk("held_bytes", rx.size(), 6);

        // reset in the middle of the REG byte
        launch(vecs[0]);
        repeat (197) @(posedge clk);
        #1;
        chk("mid_reg_scl_pulled", bus.scl_oe, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_lines", {bus.scl_oe, bus.sda_oe}, 0);
        chk("rst_mid_busy", bus.busy, 0);
        done_seen = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.done) done_seen = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.done) done_seen = 1'b1;
        end
        chk("rst_mid_no_done", done_seen, 0);
        run_txn(vecs[0], 0, 0);

`ifdef I2C_MASTER_STRETCH_EN
        // slave holds SCL low for 50 cycles from Q2 of DATA bit 3 (slot 23)
        run_txn(vecs[0], 375, 50);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_master_wr.md
# i2c_master_wr

Single-master I2C write initiator: on a `start` pulse it issues START, the 7-bit device address with W, an 8-bit register address and one data byte, then STOP, checking ACK after each byte. It is the bus-side counterpart of the team's SCL-clocked slave register file; it sits in the system clock domain and drives SCL/SDA as open-drain outputs through pad buffers.

## Interface
- `CLK_DIV`, 250, `clk` cycles per SCL quarter-period. SCL period = 4·CLK_DIV. 100 kHz at 100 MHz. Legal range ≥ 2.
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  reset: asynchronous, active-high
- `start`  in  1  request, sampled when `busy`=0
- `dev_addr`  in  7  slave address, captured on accepted `start`
- `reg_addr`  in  8  register address byte, captured on accepted `start`
- `wr_data`  in  8  data byte, captured on accepted `start`
- `busy`  out  1  transaction in progress
- `done`  out  1  one-cycle pulse at end of transaction, including aborted ones
- `ack_err`  out  1  a NACK was seen; valid with `done`, held until the next accepted `start`
- `scl_i`  in  1  SCL pad input
- `scl_oe`  out  1  1 = pull SCL low, 0 = release
- `sda_i`  in  1  SDA pad input
- `sda_oe`  out  1  1 = pull SDA low, 0 = release

## Operation
- Reset values: `busy`=0, `done`=0, `ack_err`=0, `scl_oe`=0, `sda_oe`=0, state IDLE, divider and bit counters 0.
- A `start` pulse is ignored while `busy`=1.
- Byte sequence: {dev_addr, 1'b0}, reg_addr, wr_data. Bytes are sent MSB first.
- States and transitions:
  - IDLE → START on accepted `start`.
  - START → ADDR.
  - Each byte state (ADDR, REG, DATA) → its ACK slot: ACK1, ACK2, ACK3.
  - ACK1 → REG and ACK2 → DATA when `sda_i`=0. ACK3 → STOP.
  - Any ACK slot with `sda_i`=1 sets `ack_err`=1 and goes to STOP. The remaining bytes are skipped.
  - STOP → IDLE, pulsing `done`.
- ACK slot: `sda_oe`=0, i.e. SDA is released.
- Bit slot: 4 quarters Q0..Q3, each CLK_DIV cycles.
  - Q0 and Q1: SCL low. SDA is updated at the start of Q0.
  - Q2 and Q3: SCL released. SDA is sampled on the first cycle of Q3.
- START slot: SCL released and SDA released in Q0/Q1. SDA is pulled low at the start of Q2 while SCL is high. SCL is pulled low at the end of Q3.
- STOP slot: SDA pulled low in Q0/Q1. SCL released at Q2. SDA released at the start of Q3.
- Reset mid-transaction: both lines are released immediately and no `done` is produced. The bus may see a spurious STOP; this is accepted.

## Timing
- `busy` rises on the clk edge that accepts `start`, so it is visible the next cycle.
- The first SCL/SDA activity begins on that same edge.
- Full transaction: 29 bit slots (1 START, 27 byte/ACK, 1 STOP), i.e. 116·CLK_DIV clk cycles from acceptance to `done`.
- NACK on byte k (k = 1..3): 9·k + 2 slots total.
- `done` is high for exactly 1 cycle. `busy` falls in the same cycle.
- A new `start` may be accepted in the cycle after `done`.
- Divider counter is ⌈log2(CLK_DIV)⌉ bits and wraps to 0 at CLK_DIV−1. The bit counter runs 7 down to 0.

## Configuration
- `I2C_MASTER_STRETCH_EN` defined: clock stretching is supported.
  - During Q2 and Q3 the divider holds while `scl_i`=0, i.e. while a slave is stretching.
  - The quarter count resumes once `scl_i`=1.
  - Transaction latency is then 116·CLK_DIV plus the total stretch time.
- Not defined: `scl_i` is ignored. Timing is purely divider-driven, and `scl_i` is left unconnected in logic.

## Structure
- Shared package `i2c_pkg`:
  - state enum (IDLE, START, ADDR, ACK1, REG, ACK2, DATA, ACK3, STOP)
  - quarter encoding Q0..Q3
  - constant `I2C_WR_BIT`=1'b0
  - byte width 8
- One sub-module, `i2c_quarter_tick`. It holds the CLK_DIV divider and produces a one-cycle `qtick` plus a 2-bit quarter index, with the stretch-hold input gated by the macro.
- The FSM, shift register and line drivers stay in `i2c_master_wr`.

## Test plan
- Full write: CLK_DIV=4, dev_addr=7'h50, reg_addr=8'hA5, wr_data=8'h3C, slave model ACKs all bytes.
  - Bus shows bytes 0xA0, 0xA5, 0x3C, then STOP.
  - `done` pulses at cycle 464 after acceptance; `ack_err`=0.
- Address NACK: slave model silent.
  - STOP follows the first ACK slot; `done` pulses after 11 slots (176 cycles); `ack_err`=1.
  - `ack_err` stays 1 until the next `start`.
- Data NACK on byte 3 only: `ack_err`=1, `done` at 29 slots. No extra bytes are sent.
- `start` held high throughout a transaction: exactly one transaction runs. A second one starts only on the cycle after `done`.
- Reset asserted mid-REG byte: `scl_oe`=`sda_oe`=0 on the same cycle, `busy`=0, no `done`. A later `start` runs a clean transaction.
- With `I2C_MASTER_STRETCH_EN`: slave holds SCL low for 50 cycles during DATA bit 3. `done` is delayed by exactly 50 cycles and the data byte is unchanged.
